// File: rtl/sw_input_pkg.sv
// rtl/sw_input_pkg.sv - shared constants and types for the switch input port
package sw_input_pkg;

    localparam int SW_W   = 18;
    localparam int DATA_W = 32;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam int F0_MSB = 17;
    localparam int F0_LSB = 13;
    localparam int F1_MSB = 12;
    localparam int F1_LSB = 8;
    localparam int F2_MSB = 7;
    localparam int F2_LSB = 3;
    localparam int F3_MSB = 2;
    localparam int F3_LSB = 0;

    localparam int F0_W = F0_MSB - F0_LSB + 1;
    localparam int F1_W = F1_MSB - F1_LSB + 1;
    localparam int F2_W = F2_MSB - F2_LSB + 1;
    localparam int F3_W = F3_MSB - F3_LSB + 1;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/sw_input_port_if.sv
// rtl/sw_input_port_if.sv - CPU-facing input-port bus of the switch input port
interface sw_input_port_if;
    import sw_input_pkg::*;

    logic              rd_en;
    logic [1:0]        rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        changed;
    logic [DATA_W-1:0] inp0;
    logic [DATA_W-1:0] inp1;
    logic [DATA_W-1:0] inp2;
    logic [DATA_W-1:0] inp3;

    modport master (
        output rd_en, rd_sel,
        input  rd_data, changed, inp0, inp1, inp2, inp3
    );

    modport slave (
        input  rd_en, rd_sel,
        output rd_data, changed, inp0, inp1, inp2, inp3
    );

endinterface

// File: rtl/sw_input_port_debounce.sv
// rtl/sw_input_port_debounce.sv - per-field debounce FSM (module sw_debounce)
module sw_debounce
    import sw_input_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic             commit
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_e       state;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic             held_done;

    // Commit is combinational so inp and changed move on the same edge;
    // settling back onto the old value is silent.
    assign held_done = (state == SETTLING) && (din == cand) && (cnt == CNT_LAST);
    assign commit    = held_done && (cand != stable);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= STABLE;
            stable <= '0;
            cand   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                STABLE: begin
                    if (din != stable) begin
                        cand  <= din;
                        cnt   <= '0;
                        state <= SETTLING;
                    end
                end
                SETTLING: begin
                    if (din != cand) begin
                        cand <= din;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        stable <= cand;
                        state  <= STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= STABLE;
            endcase
        end
    end

endmodule

// File: rtl/sw_input_port.sv
// rtl/sw_input_port.sv - synchronized, debounced board switches as four CPU input ports
module sw_input_port
    import sw_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [SW_W-1:0] sw,
    sw_input_port_if.slave  cpu
);

    logic [SW_W-1:0] s1;
    logic [SW_W-1:0] s2;
    logic [F0_W-1:0] st0;
    logic [F1_W-1:0] st1;
    logic [F2_W-1:0] st2;
    logic [F3_W-1:0] st3;
    logic [3:0]      commit;
    logic [3:0]      changed_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    sw_debounce #(.WIDTH(F0_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
        .clock  (clock),
        .resetn (resetn),
        .din    (s2[F0_MSB:F0_LSB]),
        .stable (st0),
        .commit (commit[0])
    );

    sw_debounce #(.WIDTH(F1_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clock  (clock),
        .resetn (resetn),
        .din    (s2[F1_MSB:F1_LSB]),
        .stable (st1),
        .commit (commit[1])
    );

    sw_debounce #(.WIDTH(F2_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clock  (clock),
        .resetn (resetn),
        .din    (s2[F2_MSB:F2_LSB]),
        .stable (st2),
        .commit (commit[2])
    );

    sw_debounce #(.WIDTH(F3_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb3 (
        .clock  (clock),
        .resetn (resetn),
        .din    (s2[F3_MSB:F3_LSB]),
        .stable (st3),
        .commit (commit[3])
    );

    assign cpu.inp0 = {{(DATA_W - F0_W){1'b0}}, st0};
    assign cpu.inp1 = {{(DATA_W - F1_W){1'b0}}, st1};
    assign cpu.inp2 = {{(DATA_W - F2_W){1'b0}}, st2};
    assign cpu.inp3 = {{(DATA_W - F3_W){1'b0}}, st3};

    // A fresh commit outranks a read clear landing on the same edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            changed_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (commit[i]) begin
                    changed_q[i] <= 1'b1;
                end else if (cpu.rd_en && (cpu.rd_sel == 2'(i))) begin
                    changed_q[i] <= 1'b0;
                end
            end
        end
    end

    assign cpu.changed = changed_q;

    always_comb begin
        cpu.rd_data = '0;
        case (cpu.rd_sel)
            2'd0: cpu.rd_data = cpu.inp0;
            2'd1: cpu.rd_data = cpu.inp1;
            2'd2: cpu.rd_data = cpu.inp2;
            2'd3: cpu.rd_data = cpu.inp3;
            default: cpu.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_sw_input_port.sv
// tb/tb_sw_input_port.sv - self-checking bench for sw_input_port
module tb_sw_input_port;

    localparam int DC_A = 4;
    localparam int DC_B = 16;

    logic        clock;
    logic        resetn_a;
    logic        resetn_b;
    logic [17:0] sw_a;
    logic [17:0] sw_b;

    int checks   = 0;
    int failures = 0;

    sw_input_port_if bus_a ();
    sw_input_port_if bus_b ();

    sw_input_port #(.DEBOUNCE_CYCLES(DC_A)) u_dut_a (
        .clock  (clock),
        .resetn (resetn_a),
        .sw     (sw_a),
        .cpu    (bus_a)
    );

    sw_input_port #(.DEBOUNCE_CYCLES(DC_B)) u_dut_b (
        .clock  (clock),
        .resetn (resetn_b),
        .sw     (sw_b),
        .cpu    (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: a field commits once its synchronized value (the switch level
    // from two edges earlier) has been seen unchanged for DC+1 edges in a row
    // and differs from the presented value.
    int          m_dc[2];
    int unsigned m_p1[2];
    int unsigned m_p2[2];
    int          m_stable[2][4];
    int          m_last[2][4];
    int          m_run[2][4];
    logic [3:0]  m_chg[2];

    function automatic int fld(int unsigned v, int f);
        case (f)
            0: return int'((v >> 13) & 31);
            1: return int'((v >> 8) & 31);
            2: return int'((v >> 3) & 31);
            default: return int'(v & 7);
        endcase
    endfunction

    task automatic model_reset(input int d);
        m_p1[d]  = 0;
        m_p2[d]  = 0;
        m_chg[d] = 4'b0000;
        for (int f = 0; f < 4; f++) begin
            m_stable[d][f] = 0;
            m_last[d][f]   = 0;
            m_run[d][f]    = 0;
        end
    endtask

    task automatic model_edge(input int d, input int unsigned swv, input logic rst_n,
                              input logic ren, input int rsel);
        int v;
        if (!rst_n) begin
            model_reset(d);
            return;
        end
        for (int f = 0; f < 4; f++) begin
            v = fld(m_p2[d], f);
            if (v == m_last[d][f]) m_run[d][f]++;
            else begin
                m_last[d][f] = v;
                m_run[d][f]  = 1;
            end
            if (m_run[d][f] == m_dc[d] + 1 && v != m_stable[d][f]) begin
                m_stable[d][f] = v;
                m_chg[d][f]    = 1'b1;
            end else if (ren && rsel == f) begin
                m_chg[d][f] = 1'b0;
            end
        end
        m_p2[d] = m_p1[d];
        m_p1[d] = swv;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("a_inp0", bus_a.inp0, 32'(m_stable[0][0]));
        chk("a_inp1", bus_a.inp1, 32'(m_stable[0][1]));
        chk("a_inp2", bus_a.inp2, 32'(m_stable[0][2]));
        chk("a_inp3", bus_a.inp3, 32'(m_stable[0][3]));
        chk("a_changed", 32'(bus_a.changed), 32'(m_chg[0]));
        chk("a_rd_data", bus_a.rd_data, 32'(m_stable[0][int'(bus_a.rd_sel)]));
        chk("b_inp0", bus_b.inp0, 32'(m_stable[1][0]));
        chk("b_inp1", bus_b.inp1, 32'(m_stable[1][1]));
        chk("b_inp2", bus_b.inp2, 32'(m_stable[1][2]));
        chk("b_inp3", bus_b.inp3, 32'(m_stable[1][3]));
        chk("b_changed", 32'(bus_b.changed), 32'(m_chg[1]));
        chk("b_rd_data", bus_b.rd_data, 32'(m_stable[1][int'(bus_b.rd_sel)]));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge(0, 32'(sw_a), resetn_a, bus_a.rd_en, int'(bus_a.rd_sel));
        model_edge(1, 32'(sw_b), resetn_b, bus_b.rd_en, int'(bus_b.rd_sel));
        #1;
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_all_a();
        for (int i = 0; i < 4; i++) begin
            bus_a.rd_en  = 1'b1;
            bus_a.rd_sel = 2'(i);
            tick();
        end
        bus_a.rd_en  = 1'b0;
        bus_a.rd_sel = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sweep[4];
        m_dc[0] = DC_A;
        m_dc[1] = DC_B;
        model_reset(0);
        model_reset(1);
        resetn_a     = 1'b0;
        resetn_b     = 1'b0;
        sw_a         = 18'h3FFFF;
        sw_b         = 18'h0;
        bus_a.rd_en  = 1'b0;
        bus_a.rd_sel = 2'd0;
        bus_b.rd_en  = 1'b0;
        bus_b.rd_sel = 2'd0;

        // Reset with all switches high, then the initial commit at edge 7.
        ticks(3);
        chk("t1_rst_inp0", bus_a.inp0, 32'd0);
        chk("t1_rst_inp3", bus_a.inp3, 32'd0);
        chk("t1_rst_changed", 32'(bus_a.changed), 32'd0);
        chk("t1_rst_rd_data", bus_a.rd_data, 32'd0);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        ticks(6);
        chk("t1_e6_inp0", bus_a.inp0, 32'd0);
        chk("t1_e6_changed", 32'(bus_a.changed), 32'd0);
        tick();
        chk("t1_e7_inp0", bus_a.inp0, 32'd31);
        chk("t1_e7_inp1", bus_a.inp1, 32'd31);
        chk("t1_e7_inp2", bus_a.inp2, 32'd31);
        chk("t1_e7_inp3", bus_a.inp3, 32'd7);
        chk("t1_e7_changed", 32'(bus_a.changed), 32'hF);

        // Bounce on field 3, then hold 5.
        sw_a = 18'h0;
        ticks(8);
        clear_all_a();
        for (int k = 0; k < 5; k++) begin
            sw_a[2:0] = (k % 2 == 0) ? 3'd3 : 3'd0;
            tick();
            tick();
            chk("t2_bounce_inp3", bus_a.inp3, 32'd0);
            chk("t2_bounce_chg3", 32'(bus_a.changed[3]), 32'd0);
        end
        sw_a[2:0] = 3'b101;
        ticks(6);
        chk("t2_e6_inp3", bus_a.inp3, 32'd0);
        tick();
        chk("t2_e7_inp3", bus_a.inp3, 32'd5);
        chk("t2_e7_changed", 32'(bus_a.changed), 32'b1000);

        // Short glitch on field 1.
        clear_all_a();
        sw_a[12:8] = 5'd1;
        ticks(2);
        sw_a[12:8] = 5'd0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t3_inp1", bus_a.inp1, 32'd0);
            chk("t3_chg1", 32'(bus_a.changed[1]), 32'd0);
        end

        // Read clear, then read clear colliding with a new commit.
        sw_a[7:3] = 5'd9;
        ticks(7);
        chk("t4_inp2", bus_a.inp2, 32'd9);
        chk("t4_chg2_set", 32'(bus_a.changed[2]), 32'd1);
        bus_a.rd_en  = 1'b1;
        bus_a.rd_sel = 2'd2;
        #1;
        chk("t4_rd_data", bus_a.rd_data, 32'd9);
        tick();
        chk("t4_chg2_clr", 32'(bus_a.changed[2]), 32'd0);
        bus_a.rd_en = 1'b0;
        sw_a[7:3]   = 5'd20;
        ticks(6);
        bus_a.rd_en = 1'b1;
        tick();
        chk("t4_coll_chg2", 32'(bus_a.changed[2]), 32'd1);
        chk("t4_coll_inp2", bus_a.inp2, 32'd20);
        bus_a.rd_en = 1'b0;

        // Independent fields committing together.
        sw_a = 18'h0;
        ticks(8);
        clear_all_a();
        sw_a[17:13] = 5'd7;
        sw_a[2:0]   = 3'd2;
        ticks(6);
        chk("t6_e6_inp0", bus_a.inp0, 32'd0);
        chk("t6_e6_inp3", bus_a.inp3, 32'd0);
        tick();
        chk("t6_e7_inp0", bus_a.inp0, 32'd7);
        chk("t6_e7_inp3", bus_a.inp3, 32'd2);
        chk("t6_e7_changed", 32'(bus_a.changed), 32'b1001);
        exp_sweep = '{7, 0, 0, 2};
        for (int i = 0; i < 4; i++) begin
            bus_a.rd_sel = 2'(i);
            #1;
            chk("t6_sweep", bus_a.rd_data, 32'(exp_sweep[i]));
        end

        // Asynchronous reset with committed values, then re-debounce.
        resetn_a = 1'b0;
        model_reset(0);
        #1;
        chk("ar_inp0", bus_a.inp0, 32'd0);
        chk("ar_changed", 32'(bus_a.changed), 32'd0);
        ticks(2);
        resetn_a = 1'b1;
        ticks(7);
        chk("ar_re_inp0", bus_a.inp0, 32'd7);
        chk("ar_re_changed", 32'(bus_a.changed), 32'b1001);

        // Reset mid-settle on the default-length instance.
        sw_b[17:13] = 5'd12;
        ticks(9);
        resetn_b = 1'b0;
        model_reset(1);
        #1;
        chk("t5_rst_inp0", bus_b.inp0, 32'd0);
        ticks(2);
        resetn_b = 1'b1;
        for (int k = 0; k < 18; k++) begin
            tick();
            chk("t5_pre_inp0", bus_b.inp0, 32'd0);
        end
        tick();
        chk("t5_e19_inp0", bus_b.inp0, 32'd12);
        chk("t5_e19_chg0", 32'(bus_b.changed[0]), 32'd1);

        // Randomized traffic against the reference.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) sw_a = 18'($urandom);
            else if ($urandom_range(0, 5) == 0) sw_a = sw_a ^ (18'd1 << $urandom_range(0, 17));
            if ($urandom_range(0, 24) == 0) sw_b = 18'($urandom);
            bus_a.rd_en  = ($urandom_range(0, 3) == 0);
            bus_a.rd_sel = 2'($urandom_range(0, 3));
            bus_b.rd_en  = ($urandom_range(0, 3) == 0);
            bus_b.rd_sel = 2'($urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
